// File: rtl/bin_to_onehot_stream.sv
// bin_to_onehot_stream
// Decodes a binary index into a one-hot vector, with valid/ready handshakes
// on both sides. A 2-entry spill register (output reg + skid reg) sits behind
// the decoder, so every output is registered and ready_o does not depend
// combinationally on ready_i.
//
// Handshake: an item moves across an interface on a rising clk_i edge where
// that interface's valid and ready are both high. The upstream side (bin_i)
// may change bin_i freely while valid_i is low. Downstream, onehot_o is held
// stable while valid_o is high and ready_i is low.
//
// Optional feature: define BIN_TO_ONEHOT_STREAM_RANGE_CHECK_EN to compile in
// the sticky out-of-range error flag (err_o, cleared by clr_err_i). Without
// it err_o is tied low and clr_err_i is ignored.
//
// state_o exposes the spill-register FSM state (0 EMPTY, 1 ONE, 2 TWO).

module bin_to_onehot_stream #(
    parameter int ONEHOT_WIDTH = 16,
    // Derived from ONEHOT_WIDTH; leave at its default.
    parameter int BIN_WIDTH    = (ONEHOT_WIDTH == 1) ? 1 : $clog2(ONEHOT_WIDTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [BIN_WIDTH-1:0]    bin_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [ONEHOT_WIDTH-1:0] onehot_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    input  logic                    clr_err_i,
    output logic                    err_o,
    output logic [1:0]              state_o
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                  state_q;
    logic [ONEHOT_WIDTH-1:0] out_q;
    logic [ONEHOT_WIDTH-1:0] skid_q;
    logic                    ready_q;
    logic                    valid_q;
    logic [ONEHOT_WIDTH-1:0] dec;
    logic                    in_fire;
    logic                    out_fire;

    // Decode: an index with no matching bit (out of range) yields all zeros.
    always_comb begin
        dec = '0;
        for (int i = 0; i < ONEHOT_WIDTH; i++) begin
            dec[i] = (bin_i == BIN_WIDTH'(i));
        end
    end

    assign in_fire  = valid_i && ready_q;
    assign out_fire = valid_q && ready_i;

    // Spill-register FSM; ready/valid are registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        out_q   <= dec;
                        valid_q <= 1'b1;
                        state_q <= S_ONE;
                    end
                end
                S_ONE: begin
                    case ({in_fire, out_fire})
                        2'b10: begin
                            // Output reg is stalled: park the new item.
                            skid_q  <= dec;
                            ready_q <= 1'b0;
                            state_q <= S_TWO;
                        end
                        2'b01: begin
                            out_q   <= '0;
                            valid_q <= 1'b0;
                            state_q <= S_EMPTY;
                        end
                        2'b11: begin
                            // Pass-through: replace the departing item.
                            out_q <= dec;
                        end
                        default: begin
                        end
                    endcase
                end
                S_TWO: begin
                    if (out_fire) begin
                        out_q   <= skid_q;
                        skid_q  <= '0;
                        ready_q <= 1'b1;
                        state_q <= S_ONE;
                    end
                end
                default: begin
                    state_q <= S_EMPTY;
                    out_q   <= '0;
                    skid_q  <= '0;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign onehot_o = out_q;
    assign state_o  = state_q;

`ifdef BIN_TO_ONEHOT_STREAM_RANGE_CHECK_EN
    logic err_q;
    logic oor_accept;

    // An accepted index that decodes to no bit is out of range.
    assign oor_accept = in_fire && ~|dec;

    // Sticky error: setting takes priority over a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (oor_accept) begin
            err_q <= 1'b1;
        end else if (clr_err_i) begin
            err_q <= 1'b0;
        end
    end

    assign err_o = err_q;
`else
    logic unused_clr_err;

    assign unused_clr_err = clr_err_i;
    assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_onehot_stream.sv
// Testbench for bin_to_onehot_stream: two instances (16 and 10 outputs)
// share all inputs, so their handshakes run in lockstep and each item is
// checked against both expected decodes.

module tb_bin_to_onehot_stream;

`ifdef BIN_TO_ONEHOT_STREAM_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]  bin_i;
    logic        valid_i;
    logic        ready_i;
    logic        clr_err;

    logic        ready16, valid16, err16;
    logic [15:0] oh16;
    logic [1:0]  st16;
    logic        ready10, valid10, err10;
    logic [9:0]  oh10;
    logic [1:0]  st10;

    bin_to_onehot_stream #(.ONEHOT_WIDTH(16)) u16 (
        .clk_i(clk), .rst_ni(rst_n), .bin_i(bin_i), .valid_i(valid_i),
        .ready_o(ready16), .onehot_o(oh16), .valid_o(valid16),
        .ready_i(ready_i), .clr_err_i(clr_err), .err_o(err16), .state_o(st16)
    );

    bin_to_onehot_stream #(.ONEHOT_WIDTH(10)) u10 (
        .clk_i(clk), .rst_ni(rst_n), .bin_i(bin_i), .valid_i(valid_i),
        .ready_o(ready10), .onehot_o(oh10), .valid_o(valid10),
        .ready_i(ready_i), .clr_err_i(clr_err), .err_o(err10), .state_o(st10)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp16(input logic [3:0] k);
        logic [15:0] one;
        one = 16'd1;
        return one << k;
    endfunction

    function automatic logic [9:0] exp10(input logic [3:0] k);
        logic [9:0] one;
        one = 10'd1;
        return (k < 4'd10) ? (one << k) : 10'd0;
    endfunction

    // ---------------- scoreboard ----------------
    logic [3:0] exp_q[$];
    logic       hold_pend = 1'b0;
    logic [15:0] held;

    // Samples at negedge the handshakes that complete on the next rising edge.
    initial begin
        logic [3:0] k;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                hold_pend = 1'b0;
            end else begin
                if (hold_pend && valid16) check_eq("hold16", 32'(oh16), 32'(held));
                hold_pend = valid16 && !ready_i;
                held      = oh16;
                if (valid16 && ready_i) begin
                    if (exp_q.size() == 0) begin
                        check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
                    end else begin
                        k = exp_q.pop_front();
                        check_eq("out16", 32'(oh16), 32'(exp16(k)));
                        check_eq("out10", 32'(oh10), 32'(exp10(k)));
                        check_eq("valid10", 32'(valid10), 32'd1);
                        check_eq("onehot0", 32'($onehot0(oh16)), 32'd1);
                    end
                end
                if (valid_i && ready16) exp_q.push_back(bin_i);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one item and return just after the edge that accepted it.
    task automatic send(input logic [3:0] k);
        logic acc;
        acc     = 1'b0;
        valid_i = 1'b1;
        bin_i   = k;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = ready16;
            tick();
        end
        if (!acc) check_eq("send_timeout", 32'(acc), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sent;
        int guard;
        logic acc;

        rst_n   = 1'b0;
        bin_i   = '0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        clr_err = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(valid16), 32'd0);
        check_eq("rst_ready", 32'(ready16), 32'd1);
        check_eq("rst_oh", 32'(oh16), 32'd0);
        check_eq("rst_err", 32'(err10), 32'd0);
        check_eq("rst_state", 32'(st16), 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Back-to-back 0, 5, 15 with ready_i high.
        ready_i = 1'b1;
        valid_i = 1'b1;
        bin_i   = 4'd0;
        @(negedge clk);
        check_eq("b2b_rdy", 32'(ready16), 32'd1);
        tick();
        bin_i = 4'd5;
        @(negedge clk);
        check_eq("b2b_oh0", 32'(oh16), 32'h0001);
        check_eq("b2b_v0", 32'(valid16), 32'd1);
        tick();
        bin_i = 4'd15;
        @(negedge clk);
        check_eq("b2b_oh1", 32'(oh16), 32'h0020);
        check_eq("b2b_v1", 32'(valid16), 32'd1);
        check_eq("b2b_rdy1", 32'(ready16), 32'd1);
        tick();
        valid_i = 1'b0;
        @(negedge clk);
        check_eq("b2b_oh2", 32'(oh16), 32'h8000);
        check_eq("b2b_oh2_10", 32'(oh10), 32'h000);
        tick();
        @(negedge clk);
        check_eq("b2b_idle", 32'(valid16), 32'd0);
        tick();

        // Backpressure: 3 then 7 with ready_i low fills the spill register.
        ready_i = 1'b0;
        send(4'd3);
        send(4'd7);
        valid_i = 1'b0;
        @(negedge clk);
        check_eq("bp_ready", 32'(ready16), 32'd0);
        check_eq("bp_ready10", 32'(ready10), 32'd0);
        check_eq("bp_state", 32'(st16), 32'd2);
        check_eq("bp_oh", 32'(oh16), 32'h0008);
        tick();
        @(negedge clk);
        check_eq("bp_hold", 32'(oh16), 32'h0008);
        tick();
        ready_i = 1'b1;
        @(negedge clk);
        check_eq("bp_rel0", 32'(oh16), 32'h0008);
        tick();
        @(negedge clk);
        check_eq("bp_rel1", 32'(oh16), 32'h0080);
        check_eq("bp_rdy_back", 32'(ready16), 32'd1);
        tick();
        @(negedge clk);
        check_eq("bp_empty", 32'(valid16), 32'd0);
        tick();

        // Out-of-range 12 on the 10-wide instance, then clear.
        send(4'd12);
        valid_i = 1'b0;
        @(negedge clk);
        check_eq("oor_valid", 32'(valid10), 32'd1);
        check_eq("oor_oh10", 32'(oh10), 32'h000);
        check_eq("oor_oh16", 32'(oh16), 32'h1000);
        check_eq("oor_err10", 32'(err10), 32'(RC));
        check_eq("oor_err16", 32'(err16), 32'd0);
        tick();
        @(negedge clk);
        check_eq("err_sticky", 32'(err10), 32'(RC));
        tick();
        clr_err = 1'b1;
        @(negedge clk);
        check_eq("err_pre_clr", 32'(err10), 32'(RC));
        tick();
        clr_err = 1'b0;
        @(negedge clk);
        check_eq("err_clr", 32'(err10), 32'd0);
        tick();

        // Set wins over a simultaneous clear.
        send(4'd12);
        valid_i = 1'b0;
        tick();
        clr_err = 1'b1;
        send(4'd13);
        clr_err = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        check_eq("set_wins", 32'(err10), 32'(RC));
        check_eq("set_wins16", 32'(err16), 32'd0);
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        @(negedge clk);
        check_eq("err_clr2", 32'(err10), 32'd0);
        tick();

        // Reset while full (state TWO).
        ready_i = 1'b0;
        send(4'd12);
        send(4'd2);
        valid_i = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_state", 32'(st16), 32'd2);
        check_eq("pre_rst_err", 32'(err10), 32'(RC));
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(valid16), 32'd0);
        check_eq("arst_oh", 32'(oh16), 32'd0);
        check_eq("arst_ready", 32'(ready16), 32'd1);
        check_eq("arst_err", 32'(err10), 32'd0);
        check_eq("arst_valid10", 32'(valid10), 32'd0);
        check_eq("arst_state", 32'(st10), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        ready_i = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check_eq("no_stale", 32'(valid16), 32'd0);
        tick();

        // Random traffic.
        sent  = 0;
        guard = 0;
        while (sent < 1000 && guard < 20000) begin
            guard++;
            @(negedge clk);
            acc = valid_i && ready16;
            tick();
            if (acc) sent++;
            if (!valid_i || acc) begin
                if ($urandom_range(0, 2) != 0) begin
                    valid_i = 1'b1;
                    bin_i   = 4'($urandom_range(0, 15));
                end else begin
                    valid_i = 1'b0;
                end
            end
            ready_i = ($urandom_range(0, 3) != 0);
        end
        valid_i = 1'b0;
        check_eq("rand_sent", 32'(sent), 32'd1000);
        ready_i = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        repeat (2) tick();
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check_eq("final_idle", 32'(valid16), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
